// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full adder (two half adders + carry OR)
// sequenced LSB-first over WIDTH cycles behind a start/busy/done handshake.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] ps;
  logic             c;
  logic [CW-1:0]    cnt;

  logic load;
  logic step;
  logic last;

  // Full adder on the current LSBs: first half adder on the operands,
  // second on the partial sum and the stored carry.
  logic ha0_s;
  logic ha0_c;
  logic fa_s;
  logic ha1_c;
  logic fa_c;

  assign ha0_s = sa[0] ^ sb[0];
  assign ha0_c = sa[0] & sb[0];
  assign fa_s  = ha0_s ^ c;
  assign ha1_c = ha0_s & c;
  assign fa_c  = ha0_c | ha1_c;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST_BIT) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand/partial-sum shifters, carry, counter and handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      ps   <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next == RUN);
      done <= (state_next == DONE);
      if (load) begin
        sa  <= a_in;
        sb  <= b_in;
        ps  <= '0;
        c   <= 1'b0;
        cnt <= '0;
      end else if (step) begin
        sa  <= {1'b0, sa[WIDTH-1:1]};
        sb  <= {1'b0, sb[WIDTH-1:1]};
        ps  <= {fa_s, ps[WIDTH-1:1]};
        c   <= fa_c;
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Result register: updated only on the final bit, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_out   <= '0;
      carry_out <= 1'b0;
    end else if (last) begin
      sum_out   <= {fa_s, ps[WIDTH-1:1]};
      carry_out <= fa_c;
    end
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller. It owns a single 1-bit full-adder datapath, built from two half adders plus an OR on the carries, and sequences it over WIDTH clock cycles to add two WIDTH-bit operands LSB-first. Callers use a start/busy/done handshake. Results are held in an output register until the next operation completes. It sits between a requester, such as a test sequencer or a small ALU front end, and the gate-level half-adder cells.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled at rising edge, accepted only in IDLE or DONE.
- a_in  input  WIDTH  operand A; captured on the accepting edge.
- b_in  input  WIDTH  operand B; captured on the accepting edge.
- busy  output  1  high while bits are being processed (state RUN).
- done  output  1  one-cycle pulse; result registers valid.
- sum_out  output  WIDTH  registered sum A+B mod 2^WIDTH.
- carry_out  output  1  registered carry out of bit WIDTH-1.

## Operation
- Internal state:
  - operand shift registers sa, sb (WIDTH bits each);
  - partial-sum shift register ps (WIDTH);
  - carry flop c;
  - bit counter cnt (ceil(log2(WIDTH)) bits);
  - FSM state.
- FSM states IDLE, RUN, DONE; encoding is free.
- IDLE:
  - start=1: load sa<=a_in, sb<=b_in, c<=0, cnt<=0, ps<=0; go to RUN.
  - otherwise stay in IDLE.
- RUN, each cycle:
  - s = sa[0] ^ sb[0] ^ c;
  - c <= (sa[0]&sb[0]) | (c&(sa[0]^sb[0]));
  - ps <= {s, ps[WIDTH-1:1]};
  - sa, sb shift right by 1, filling with 0;
  - cnt <= cnt+1.
  - When cnt==WIDTH-1 the final bit is processed on that edge. On the same edge: sum_out <= {s, ps[WIDTH-1:1]}, carry_out <= final carry, state <= DONE.
- DONE (lasts exactly one cycle unless restarted):
  - done=1.
  - start=1: reload operands as in IDLE; go to RUN (back-to-back).
  - otherwise go to IDLE.
- start in RUN is ignored. It is not queued. Operands are not re-sampled.
- sum_out and carry_out change only on the final RUN edge. During RUN they hold the previous result.
- Datapath arithmetic is unsigned; overflow appears only in carry_out.

## Timing
- Reset (rst=1 at a rising edge), from any state:
  - state=IDLE;
  - busy=0, done=0, sum_out=0, carry_out=0;
  - sa, sb, ps, c, cnt cleared.
  - rst has priority over start.
- Reset mid-RUN discards the partial result. No done pulse follows.
- Accepting edge E0 (start=1 in IDLE): busy=1 from just after E0.
- Bits 0..WIDTH-1 are processed on edges E1..EWIDTH.
- After EWIDTH: busy=0, done=1, sum_out and carry_out valid.
- After E(WIDTH+1): done=0, back in IDLE. If start=1 at E(WIDTH+1), busy=1 again instead.
- Latency from accepting edge to done: WIDTH+1 edges (WIDTH cycles busy, then 1 cycle done).
- Throughput with back-to-back starts: one result per WIDTH+1 cycles.
- busy and done are registered, mutually exclusive, and never high together.

## Test plan
- Reset, then start with a_in=8'h00, b_in=8'h00 (WIDTH=8):
  - busy high for exactly 8 cycles;
  - done pulses 1 cycle, 9 edges after start;
  - sum_out=8'h00, carry_out=0.
- a_in=8'hFF, b_in=8'h01: sum_out=8'h00, carry_out=1. Check full carry ripple through all bits.
- a_in=8'hA5, b_in=8'h5A: sum_out=8'hFF, carry_out=0. Then a_in=8'h80, b_in=8'h80: sum_out=8'h00, carry_out=1.
- Start 8'h03+8'h04, then pulse start with 8'hFF+8'hFF at the 3rd busy cycle:
  - second request is ignored;
  - result is sum_out=8'h07, carry_out=0;
  - exactly one done pulse.
- Start 8'h10+8'h20 with sum_out previously 8'h07; assert rst at the 4th busy cycle:
  - next cycle busy=0, done=0, sum_out=8'h00, carry_out=0;
  - no done pulse within the following 12 cycles.
- Back-to-back: hold start=1 with 8'h01+8'h01, change operands to 8'hFE+8'h03 during the DONE cycle:
  - done pulses twice, 9 cycles apart;
  - results 8'h02/0, then 8'h01/1.
